// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Program-counter controller for the instruction ROM. Launches one
//            of NPROG preloaded programs on a host Start handshake, advances
//            the PC every cycle, applies stall/halt/jump/branch requests from
//            decode, and reports Done back to the host.
//
// Ports    : Clk, Reset_n (async, active low)
//            Start, ProgSel            host launch request / program index
//            Stall, Halt, Jump, Branch decode control (priority in that order)
//            JumpTarget, BranchOff     absolute target / signed PC offset
//            InstAddress               PC, drives the ROM address
//            FetchValid, Busy, Done    registered status
//            WrapErr                   sticky sequential-wrap flag
//            CycleCount                RUN cycles of current/last program
//
// Option   : CYCLE_COUNT_EN - when defined, CycleCount counts RUN cycles
//            (stalls included, saturating). When undefined, no counter is
//            built and CycleCount is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int          A      = 16,
  parameter int          OFFW   = 8,
  parameter int          NPROG  = 4,
  parameter logic [A-1:0] START0 = 16'h0000,
  parameter logic [A-1:0] START1 = 16'h0000,
  parameter logic [A-1:0] START2 = 16'h0000,
  parameter logic [A-1:0] START3 = 16'h0000
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Jump,
  input  logic [A-1:0]    JumpTarget,
  input  logic            Branch,
  input  logic [OFFW-1:0] BranchOff,
  output logic [A-1:0]    InstAddress,
  output logic            FetchValid,
  output logic            Busy,
  output logic            Done,
  output logic            WrapErr,
  output logic [15:0]     CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic           wrap_err_q, wrap_err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fetch_valid_q, fetch_valid_d;

  logic [A-1:0]   entry_addr;
  logic [A-1:0]   branch_sext;
  logic [A-1:0]   pc_inc;

  // Offset is sign-extended to the PC width; the add wraps modulo 2^A.
  assign branch_sext = {{(A-OFFW){BranchOff[OFFW-1]}}, BranchOff};
  assign pc_inc      = pc_q + {{(A-1){1'b0}}, 1'b1};

  // Program entry lookup; indices beyond NPROG fall back to program 0.
  always_comb begin
    entry_addr = START0;
    if ({30'd0, ProgSel} < NPROG) begin
      case (ProgSel)
        2'd1:    entry_addr = START1;
        2'd2:    entry_addr = START2;
        2'd3:    entry_addr = START3;
        default: entry_addr = START0;
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wrap_err_d = wrap_err_q;
`ifdef CYCLE_COUNT_EN
    cycle_cnt_d = cycle_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_RUN;
          pc_d       = entry_addr;
          wrap_err_d = 1'b0;
`ifdef CYCLE_COUNT_EN
          cycle_cnt_d = 16'd0;
`endif
        end
      end

      S_RUN: begin
`ifdef CYCLE_COUNT_EN
        // Every cycle spent in RUN counts, including stalled ones.
        if (cycle_cnt_q != 16'hFFFF) begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
`endif
        if (Stall) begin
          // Datapath busy: PC and all other controls frozen this cycle.
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = S_DONE;
        end else if (Jump) begin
          pc_d = JumpTarget;
        end else if (Branch) begin
          pc_d = pc_q + branch_sext;
        end else begin
          pc_d = pc_inc;
          if (pc_q == {A{1'b1}}) begin
            wrap_err_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Host must drop Start before another launch is possible.
        if (!Start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode so they
    // change on the same edge as the state itself.
    busy_d        = (state_d == S_RUN);
    fetch_valid_d = (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      wrap_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
`ifdef CYCLE_COUNT_EN
      cycle_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wrap_err_q    <= wrap_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fetch_valid_q <= fetch_valid_d;
`ifdef CYCLE_COUNT_EN
      cycle_cnt_q   <= cycle_cnt_d;
`endif
    end
  end

  assign InstAddress = pc_q;
  assign FetchValid  = fetch_valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign WrapErr     = wrap_err_q;

`ifdef CYCLE_COUNT_EN
  assign CycleCount  = cycle_cnt_q;
`else
  assign CycleCount  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. A stimulus process
//            drives directed and random control patterns and pushes the
//            expected post-edge outputs, computed by a behavioural model,
//            into a queue; a monitor pops and compares on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [15:0] P_START0 = 16'hFFFE;
  localparam logic [15:0] P_START1 = 16'h1200;
  localparam logic [15:0] P_START2 = 16'h0040;
  localparam logic [15:0] P_START3 = 16'h7FF0;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Stall;
  logic        Halt;
  logic        Jump;
  logic [15:0] JumpTarget;
  logic        Branch;
  logic [7:0]  BranchOff;
  logic [15:0] InstAddress;
  logic        FetchValid;
  logic        Busy;
  logic        Done;
  logic        WrapErr;
  logic [15:0] CycleCount;

  fetch_sequencer #(
    .A(16), .OFFW(8), .NPROG(4),
    .START0(P_START0), .START1(P_START1),
    .START2(P_START2), .START3(P_START3)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
    .Stall(Stall), .Halt(Halt), .Jump(Jump), .JumpTarget(JumpTarget),
    .Branch(Branch), .BranchOff(BranchOff), .InstAddress(InstAddress),
    .FetchValid(FetchValid), .Busy(Busy), .Done(Done), .WrapErr(WrapErr),
    .CycleCount(CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int   id;
    int   pc;
    bit   busy;
    bit   done;
    bit   wrap;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Behavioural model: phase 0 = waiting, 1 = running, 2 = finished.
  int   m_phase;
  int   m_pc;
  bit   m_wrap;
  int   m_cnt;
  int   entry_tbl [4];

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit st, input int sel, input bit stl, input bit hlt,
                            input bit jmp, input int jt, input bit br, input int off);
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1;
        m_pc    = entry_tbl[sel];
        m_wrap  = 0;
        m_cnt   = 0;
      end
    end else if (m_phase == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (stl) begin
        // nothing moves
      end else if (hlt) begin
        m_phase = 2;
      end else if (jmp) begin
        m_pc = jt;
      end else if (br) begin
        m_pc = (m_pc + off + 65536) % 65536;
      end else if (m_pc == 65535) begin
        m_pc   = 0;
        m_wrap = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end else begin
      if (!st) m_phase = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, push the expectation.
  task automatic step(input bit st, input int sel, input bit stl, input bit hlt,
                      input bit jmp, input int jt, input bit br, input int off);
    exp_t e;
    Start = st; ProgSel = 2'(sel); Stall = stl; Halt = hlt;
    Jump = jmp; JumpTarget = 16'(jt); Branch = br; BranchOff = 8'(off);
    @(posedge Clk);
    #1;
    model_edge(st, sel, stl, hlt, jmp, jt, br, off);
    e.id   = txn;
    e.pc   = m_pc;
    e.busy = (m_phase == 1);
    e.done = (m_phase == 2);
    e.wrap = m_wrap;
`ifdef CYCLE_COUNT_EN
    e.cnt  = m_cnt;
`else
    e.cnt  = 0;
`endif
    txn = txn + 1;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Immediate output check while reset is held (no edge involved).
  task automatic check_reset_outputs(input string tag);
    total = total + 1;
    if (InstAddress !== 16'h0 || FetchValid !== 1'b0 || Busy !== 1'b0 ||
        Done !== 1'b0 || WrapErr !== 1'b0 || CycleCount !== 16'h0) begin
      bad = bad + 1;
      $display("FAIL %s: got pc=%h fv=%b busy=%b done=%b wrap=%b cnt=%0d, expected all zero",
               tag, InstAddress, FetchValid, Busy, Done, WrapErr, CycleCount);
    end
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare them
  // against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total = total + 1;
        if (InstAddress !== 16'(e.pc) || FetchValid !== e.busy || Busy !== e.busy ||
            Done !== e.done || WrapErr !== e.wrap || CycleCount !== 16'(e.cnt)) begin
          bad = bad + 1;
          $display("FAIL txn%0d: got pc=%h fv=%b busy=%b done=%b wrap=%b cnt=%0d; expected pc=%h busy=%b done=%b wrap=%b cnt=%0d",
                   e.id, InstAddress, FetchValid, Busy, Done, WrapErr, CycleCount,
                   16'(e.pc), e.busy, e.done, e.wrap, e.cnt);
        end
      end
    end
  end

  initial begin
    entry_tbl[0] = P_START0; entry_tbl[1] = P_START1;
    entry_tbl[2] = P_START2; entry_tbl[3] = P_START3;
    model_reset();
    Reset_n = 1'b0; Start = 0; ProgSel = 0; Stall = 0; Halt = 0;
    Jump = 0; JumpTarget = 0; Branch = 0; BranchOff = 0;

    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset_hold");
    Reset_n = 1'b1;

    // Idle with Start low: nothing moves.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 16'h1234, 1, 5);

    // Program 2 launch and sequential fetch 0x40..0x45.
    step(1, 2, 0, 0, 0, 0, 0, 0);
    run(5);
    step(0, 0, 0, 0, 0, 0, 1, -3);          // 0x45 - 3 -> 0x42
    step(0, 0, 0, 0, 1, 16'h0080, 1, 7);    // jump wins over branch
    step(0, 0, 1, 1, 0, 0, 0, 0);           // stall masks halt
    step(0, 0, 0, 1, 0, 0, 0, 0);           // halt at 0x80
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0); // held in DONE
    step(0, 0, 0, 0, 0, 0, 0, 0);           // release -> IDLE

    // Program 0 wrap: 0xFFFE -> 0xFFFF -> 0x0000 with sticky WrapErr.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run(4);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);           // relaunch clears WrapErr
    step(0, 0, 0, 0, 1, 16'hFFFF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);           // branch across top: no WrapErr
    run(2);

    // Asynchronous reset between edges, mid-run.
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_midrun");
    model_reset();
    #2;
    Reset_n = 1'b1;

    // Cycle count run: launch, then 10 RUN cycles (2 stalled, last is halt).
    step(1, 1, 0, 0, 0, 0, 0, 0);
    run(3);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    run(3);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    run(1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 65535)),
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 255)) - 128);
    end

    @(negedge Clk);
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
